// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, PC step and fetch-queue entry type for the fetch unit
package fetch_pkg;
  localparam int PC_W = 64;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] PC_STEP = 64'd4;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with flush
// Ports: clock/reset (sync, active-high); flush empties the queue; push/push_data write the tail;
// pop consumes the head; head is the oldest entry; full/empty/count report occupancy.
// A pop and a push in the same cycle both succeed even when full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign head = mem[rp];
  assign count = cnt;
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clock)
    if (do_push && !flush) mem[wp] <= push_data;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with credit-limited requests, in-order tag queue and fetch queue
// Ports: clock/reset (sync, active-high); enable gates new requests; redirect_valid/redirect_pc retarget the PC;
// imem_req_* issue PC-addressed requests; imem_rsp_* return in-order instruction words;
// ifq_* present the oldest fetched {pc, instr} to decode; stall_count exists only with FETCH_STALL_CNT_EN.
// Credits count in-flight requests (live and to-be-dropped) plus queued entries, and treat a same-cycle
// pop as already freed so the queue streams without bubbles.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 64'h0,
  parameter int DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               ifq_valid,
  input  logic               ifq_ready,
  output logic [INSTR_W-1:0] ifq_instr,
  output logic [PC_W-1:0]    ifq_pc
`ifdef FETCH_STALL_CNT_EN
  , output logic [15:0]      stall_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 3;
  logic [PC_W-1:0] pc;
  logic pend;
  logic [AW:0] drop, tag_cnt, occ;
  logic [PC_W-1:0] tag_mem [DEPTH];
  logic [AW-1:0] tag_wp, tag_rp;
  logic pop, accept, keep_rsp, drop_rsp, credit_ok, full, empty;
  fetch_entry_t head;
  assign pop = ifq_valid && ifq_ready;
  assign credit_ok = CW'(tag_cnt) + CW'(drop) + CW'(occ) - CW'(pop) < CW'(DEPTH);
  // pend keeps an unaccepted request up even if enable drops or credits are re-evaluated
  assign imem_req_valid = !reset && !redirect_valid && (pend || (enable && credit_ok));
  assign imem_req_addr = pc;
  assign accept = imem_req_valid && imem_req_ready;
  // responses to requests issued before a redirect are swallowed until drop reaches zero
  assign drop_rsp = imem_rsp_valid && drop != '0;
  assign keep_rsp = imem_rsp_valid && drop == '0;
  assign ifq_valid = !empty;
  assign ifq_pc = head.pc;
  assign ifq_instr = head.instr;
  fetch_fifo #(.DEPTH(DEPTH)) u_ifq (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (keep_rsp && !redirect_valid),
    .push_data ('{pc: tag_mem[tag_rp], instr: imem_rsp_data}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (occ)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
      pend <= 1'b0;
      drop <= '0;
      tag_wp <= '0;
      tag_rp <= '0;
      tag_cnt <= '0;
    end else if (redirect_valid) begin
      pc <= align_pc(redirect_pc);
      pend <= 1'b0;
      tag_wp <= '0;
      tag_rp <= '0;
      tag_cnt <= '0;
      drop <= drop + tag_cnt - (AW+1)'(imem_rsp_valid);
    end else begin
      if (accept) pc <= pc + PC_STEP;
      if (accept) tag_wp <= tag_wp + AW'(1);
      if (keep_rsp) tag_rp <= tag_rp + AW'(1);
      tag_cnt <= tag_cnt + (AW+1)'(accept) - (AW+1)'(keep_rsp);
      drop <= drop - (AW+1)'(drop_rsp);
      pend <= imem_req_valid && !imem_req_ready;
    end
  end
  always_ff @(posedge clock)
    if (accept) tag_mem[tag_wp] <= pc;
  // the credit rule makes a push into a full queue without a pop impossible
  assert property (@(posedge clock) disable iff (reset) !(full && keep_rsp && !redirect_valid && !pop));
`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clock)
    if (reset) stall_count <= '0;
    else if (enable && !ifq_valid && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, directed corner sequences and randomized run against a queue-based model
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [63:0] RPC = 64'h1000;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0, redirect_valid = 1'b0, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0, ifq_ready = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic [31:0] imem_rsp_data = '0;
  logic imem_req_valid, ifq_valid;
  logic [63:0] imem_req_addr, ifq_pc;
  logic [31:0] ifq_instr;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_count;
`endif
  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ifq_valid      (ifq_valid),
    .ifq_ready      (ifq_ready),
    .ifq_instr      (ifq_instr),
    .ifq_pc         (ifq_pc)
`ifdef FETCH_STALL_CNT_EN
    , .stall_count  (stall_count)
`endif
  );
  always #5 clock = ~clock;
  typedef struct { logic [63:0] addr; int due; bit live; } req_t;
  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
  typedef struct {
    logic en, rdy, ird, rv;
    logic [63:0] rpc;
    int lat;
    logic xv;
    logic [63:0] xaddr;
    logic xiv;
    logic [63:0] xpc;
  } vec_t;
  req_t mq[$];
  ent_t ifq[$];
  vec_t tbl[$];
  logic [63:0] m_pc;
  bit m_pend;
  int m_stall, last_due, cyc, errors, checks;
  logic o_rv, o_iv;
  logic [63:0] o_addr, o_ipc;
  logic [31:0] o_ii;
  function automatic logic [31:0] word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b1;
    imem_req_ready = 1'b1;
    ifq_ready = 1'b1;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    #1 chk("rst_req_valid", imem_req_valid, 0);
    @(posedge clock);
    #1;
    chk("rst_ifq_valid", ifq_valid, 0);
    chk("rst_req_addr", imem_req_addr, RPC);
`ifdef FETCH_STALL_CNT_EN
    chk("rst_stall_count", stall_count, 0);
`endif
    @(negedge clock);
    reset = 1'b0;
    m_pc = RPC;
    m_pend = 0;
    m_stall = 0;
    last_due = 0;
    mq.delete();
    ifq.delete();
  endtask
  task automatic tick(input logic en, rdy, ird, rv, input logic [63:0] rpc, input int lat);
    logic rsp, xv, xiv, pop;
    int used, d;
    req_t h;
    enable = en;
    imem_req_ready = rdy;
    ifq_ready = ird;
    redirect_valid = rv;
    redirect_pc = rpc;
    rsp = mq.size() > 0 && mq[0].due <= cyc;
    imem_rsp_valid = rsp;
    if (rsp) imem_rsp_data = word(mq[0].addr);
    else imem_rsp_data = $urandom;
    #1;
    o_rv = imem_req_valid;
    o_addr = imem_req_addr;
    o_iv = ifq_valid;
    o_ipc = ifq_pc;
    o_ii = ifq_instr;
    xiv = ifq.size() > 0;
    pop = xiv && ird;
    used = mq.size() + ifq.size() - (pop ? 1 : 0);
    xv = !rv && (m_pend || (en && used < DEPTH));
    chk("req_valid", o_rv, xv);
    chk("req_addr", o_addr, m_pc);
    chk("ifq_valid", o_iv, xiv);
    if (xiv) begin
      chk("ifq_pc", o_ipc, ifq[0].pc);
      chk("ifq_instr", o_ii, ifq[0].instr);
    end
`ifdef FETCH_STALL_CNT_EN
    chk("stall_count", stall_count, m_stall);
    if (en && !xiv && m_stall < 16'hFFFF) m_stall++;
`endif
    if (pop) void'(ifq.pop_front());
    if (rsp) begin
      h = mq.pop_front();
      if (h.live && !rv) ifq.push_back('{pc: h.addr, instr: word(h.addr)});
    end
    if (rv) begin
      ifq.delete();
      foreach (mq[i]) mq[i].live = 0;
      m_pc = {rpc[63:2], 2'b00};
      m_pend = 0;
    end else begin
      if (xv && rdy) begin
        d = cyc + lat;
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        mq.push_back('{addr: m_pc, due: d, live: 1'b1});
        m_pc = m_pc + 64'd4;
      end
      m_pend = xv && !rdy;
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask
  task automatic add(input logic ird, input logic xv, input logic [63:0] xaddr, input logic xiv, input logic [63:0] xpc);
    tbl.push_back('{en: 1'b1, rdy: 1'b1, ird: ird, rv: 1'b0, rpc: 64'h0, lat: 1, xv: xv, xaddr: xaddr, xiv: xiv, xpc: xpc});
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    bit found;
    errors = 0;
    checks = 0;
    cyc = 0;
    add(1, 1, 64'h1000, 0, 64'h0);
    add(1, 1, 64'h1004, 0, 64'h0);
    add(1, 1, 64'h1008, 1, 64'h1000);
    add(1, 1, 64'h100c, 1, 64'h1004);
    add(1, 1, 64'h1010, 1, 64'h1008);
    for (int i = 0; i < 10; i++) add(0, 0, 64'h1014, 1, 64'h100c);
    add(1, 1, 64'h1014, 1, 64'h100c);
    add(1, 1, 64'h1018, 1, 64'h1010);
    add(1, 1, 64'h101c, 1, 64'h1014);
    @(negedge clock);
    do_reset();
    foreach (tbl[i]) begin
      tick(tbl[i].en, tbl[i].rdy, tbl[i].ird, tbl[i].rv, tbl[i].rpc, tbl[i].lat);
      chk("tbl_req_valid", o_rv, tbl[i].xv);
      chk("tbl_req_addr", o_addr, tbl[i].xaddr);
      chk("tbl_ifq_valid", o_iv, tbl[i].xiv);
      if (tbl[i].xiv) chk("tbl_ifq_pc", o_ipc, tbl[i].xpc);
    end
    do_reset();
    tick(1, 1, 1, 0, 64'h0, 3);
    tick(1, 1, 1, 0, 64'h0, 3);
    tick(1, 1, 1, 1, 64'h2003, 3);
    chk("redir_req_valid", o_rv, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1, 1, 1, 0, 64'h0, 1);
      if (o_iv) begin
        chk("redir_first_pc", o_ipc, 64'h2000);
        found = 1;
      end
    end
    if (!found) chk("redir_first_pc_timeout", 0, 1);
    do_reset();
    tick(1, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    tick(1, 1, 1, 0, 64'h0, 1);
    chk("wrap_req_valid", o_rv, 1);
    chk("wrap_last_addr", o_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(1, 1, 1, 0, 64'h0, 1);
    chk("wrap_next_addr", o_addr, 64'h0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 1, 0, 64'h0, 1);
      chk("hold_req_valid", o_rv, 1);
      chk("hold_req_addr", o_addr, RPC);
`ifdef FETCH_STALL_CNT_EN
      chk("stall_inc", stall_count, 64'(i + 1));
`endif
    end
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else tick($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 15) == 0, {$urandom, $urandom}, int'($urandom_range(1, 4)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0: PC value loaded on reset.
REQ-002 Parameter DEPTH, default 2: fetch-queue entries and the maximum number of outstanding memory requests; legal values 2..8, power of two.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  when high, new instruction-memory requests are permitted.
REQ-006 redirect_valid  input  1  branch/exception redirect strobe, single cycle.
REQ-007 redirect_pc  input  64  redirect target; bits [1:0] ignored and treated as 0.
REQ-008 imem_req_valid  output  1  request to instruction memory.
REQ-009 imem_req_ready  input  1  memory accepts request.
REQ-010 imem_req_addr  output  64  request byte address; equals current PC.
REQ-011 imem_rsp_valid  input  1  in-order response strobe, minimum 1 cycle after acceptance.
REQ-012 imem_rsp_data  input  32  instruction word.
REQ-013 ifq_valid  output  1  decode-side entry valid.
REQ-014 ifq_ready  input  1  decode consumes entry.
REQ-015 ifq_instr  output  32  instruction word.
REQ-016 ifq_pc  output  64  address of ifq_instr.
REQ-017 stall_count  output  16  present only with FETCH_STALL_CNT_EN.

Function
REQ-018 Request issued when enable=1, redirect_valid=0, and (outstanding + queue occupancy) < DEPTH.
REQ-019 Accept = imem_req_valid && imem_req_ready; on accept PC <= PC + 4, wrapping modulo 2^64.
REQ-020 imem_req_valid and imem_req_addr SHALL remain stable until accepted, except when cancelled by redirect or reset.
REQ-021 Each accepted request's PC SHALL be recorded in an in-order tag queue; each response pairs with the oldest tag and is written to the fetch queue in the same cycle.
REQ-022 Fetch queue is FIFO; ifq_* outputs present the head entry; pop = ifq_valid && ifq_ready.
REQ-023 Simultaneous push and pop on a full queue SHALL both succeed; push on a full queue without pop cannot occur, because the credit rule (REQ-018) prevents it.
REQ-024 ifq_instr/ifq_pc SHALL hold stable while ifq_valid=1 and ifq_ready=0.
REQ-025 Redirect: in the same edge, PC <= {redirect_pc[63:2],2'b00}, fetch queue flushed, tag queue cleared, imem_req_valid=0 during the redirect cycle.
REQ-026 After a redirect, the unit SHALL count requests still in flight and discard that many subsequent responses without writing them.
REQ-027 Redirect has priority over pop, push and request in the same cycle; a pop in the redirect cycle is still completed by decode, but no entry survives.
REQ-028 enable=0 blocks only new requests; responses, pops and redirects proceed.
REQ-029 First request after reset or redirect appears the following cycle at the earliest (1-cycle redirect-to-request latency).

Reset
REQ-030 On reset: PC=RESET_PC, imem_req_valid=0, ifq_valid=0, outstanding=0, drop count=0, stall_count=0.
REQ-031 Reset mid-operation SHALL abandon all in-flight requests; responses arriving after reset deasserts are outside contract, and memory is reset together with this unit.

Configuration
REQ-032 With FETCH_STALL_CNT_EN defined, stall_count SHALL increment by 1, saturating at 16'hFFFF, each cycle in which enable=1 and ifq_valid=0.
REQ-033 Without FETCH_STALL_CNT_EN, the stall_count port and its counter SHALL not exist.

Structure
REQ-034 Shared package fetch_pkg holds PC_W=64, INSTR_W=32, PC_STEP=4 and typedef fetch_entry_t {pc, instr}.
REQ-035 Fetch queue SHALL be the sub-module fetch_fifo (synchronous FIFO of fetch_entry_t with DEPTH entries, flush, full and empty outputs).

Verification
REQ-036 Reset with RESET_PC=0x1000, memory always ready, 1-cycle latency, ifq_ready=1 -> ifq_pc sequence 0x1000, 0x1004, 0x1008, with no bubbles after the first.
REQ-037 ifq_ready=0 for 10 cycles -> exactly DEPTH entries are buffered, imem_req_valid=0 once credits are exhausted, and outputs stay stable.
REQ-038 Redirect to 0x2003 while 2 requests are in flight -> both late responses are dropped, and the next ifq_pc is 0x2000.
REQ-039 PC=0xFFFF_FFFF_FFFF_FFFC accepted -> next imem_req_addr is 0x0.
REQ-040 imem_req_ready=0 for 5 cycles -> imem_req_addr is held; with FETCH_STALL_CNT_EN, stall_count increments while the queue is empty.
